// File: rtl/sys_ctrl_v2.sv
// sys_ctrl_v2: decodes UART RX command frames into register-file writes/reads,
// ALU operations and TX FIFO pushes; multi-byte ALU results go out LSB first.
module sys_ctrl_v2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     FIFO_FULL,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     EN,
  output logic                     CLK_EN,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     W_INC,
  output logic                     clk_div_en,
  output logic                     FRAME_ERR
);

  localparam int NB       = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int RW       = NB * DATA_WIDTH;
  localparam int KW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OPA    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_OPB    = ADDR_WIDTH'(1'b1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_RD_PUSH  = 4'd5,
    S_ALU_A    = 4'd6,
    S_ALU_B    = 4'd7,
    S_ALU_FN   = 4'd8,
    S_ALU_WAIT = 4'd9,
    S_ALU_PUSH = 4'd10
  } state_t;

  state_t                   state_q;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q;
  logic                     en_q;
  logic                     clk_en_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     wr_en_q;
  logic                     rd_en_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic [DATA_WIDTH-1:0]    tx_data_q;
  logic                     w_inc_q;
  logic                     clk_div_en_q;
  logic                     frame_err_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic [RW-1:0]            res_q;
  logic [KW-1:0]            k_q;
  logic [TW-1:0]            tmo_q;

  logic timed_s;
  logic event_s;
  logic busy_s;
  logic tmo_hit_s;

  // Classify the current state: timed wait, its progress event, and busy (stray bytes dropped)
  always_comb begin
    timed_s   = 1'b0;
    event_s   = 1'b0;
    busy_s    = 1'b0;
    tmo_hit_s = 1'b0;
    case (state_q)
      S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FN: begin
        timed_s = 1'b1;
        event_s = RX_D_VLD;
      end
      S_RD_WAIT: begin
        timed_s = 1'b1;
        event_s = RdData_Valid;
        busy_s  = 1'b1;
      end
      S_ALU_WAIT: begin
        timed_s = 1'b1;
        event_s = OUT_Valid;
        busy_s  = 1'b1;
      end
      S_RD_PUSH, S_ALU_PUSH: begin
        busy_s = 1'b1;
      end
      default: begin
        timed_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
    if (TMO_EN && timed_s && !event_s && (tmo_q == TW'(TMO_LAST))) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Inter-byte idle counter; any state change or accepted event restarts it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_q <= {TW{1'b0}};
    end else if (TMO_EN && timed_s && !event_s && !tmo_hit_s) begin
      tmo_q <= tmo_q + TW'(1'b1);
    end else begin
      tmo_q <= {TW{1'b0}};
    end
  end

  // Frame FSM with all outputs registered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      alu_fun_q    <= {ALU_FUN_WIDTH{1'b0}};
      en_q         <= 1'b0;
      clk_en_q     <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_data_q    <= {DATA_WIDTH{1'b0}};
      tx_data_q    <= {DATA_WIDTH{1'b0}};
      w_inc_q      <= 1'b0;
      clk_div_en_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_data_q    <= {DATA_WIDTH{1'b0}};
      res_q        <= {RW{1'b0}};
      k_q          <= {KW{1'b0}};
    end else begin
      en_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      w_inc_q      <= 1'b0;
      clk_div_en_q <= 1'b1;
      frame_err_q  <= (RX_D_VLD && busy_s) || tmo_hit_s;
      if (tmo_hit_s) begin
        state_q  <= S_IDLE;
        clk_en_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (RX_D_VLD) begin
              case (RX_P_DATA)
                CMD_WR:      state_q <= S_WR_ADDR;
                CMD_RD:      state_q <= S_RD_ADDR;
                CMD_ALU_OP:  state_q <= S_ALU_A;
                CMD_ALU_NOP: state_q <= S_ALU_FN;
                default:     frame_err_q <= 1'b1;
              endcase
            end
          end
          S_WR_ADDR: begin
            if (RX_D_VLD) begin
              addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
              state_q <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (RX_D_VLD) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= RX_P_DATA;
              state_q   <= S_IDLE;
            end
          end
          S_RD_ADDR: begin
            if (RX_D_VLD) begin
              rd_en_q <= 1'b1;
              addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
              state_q <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (RdData_Valid) begin
              rd_data_q <= RdData;
              state_q   <= S_RD_PUSH;
            end
          end
          S_RD_PUSH: begin
            if (!FIFO_FULL) begin
              w_inc_q   <= 1'b1;
              tx_data_q <= rd_data_q;
              state_q   <= S_IDLE;
            end
          end
          S_ALU_A: begin
            if (RX_D_VLD) begin
              wr_en_q   <= 1'b1;
              addr_q    <= ADDR_OPA;
              wr_data_q <= RX_P_DATA;
              state_q   <= S_ALU_B;
            end
          end
          S_ALU_B: begin
            if (RX_D_VLD) begin
              wr_en_q   <= 1'b1;
              addr_q    <= ADDR_OPB;
              wr_data_q <= RX_P_DATA;
              state_q   <= S_ALU_FN;
            end
          end
          S_ALU_FN: begin
            if (RX_D_VLD) begin
              alu_fun_q <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
              en_q      <= 1'b1;
              clk_en_q  <= 1'b1;
              state_q   <= S_ALU_WAIT;
            end
          end
          S_ALU_WAIT: begin
            if (OUT_Valid) begin
              res_q    <= RW'(ALU_OUT);
              clk_en_q <= 1'b0;
              k_q      <= {KW{1'b0}};
              state_q  <= S_ALU_PUSH;
            end
          end
          S_ALU_PUSH: begin
            // Result is shifted down so the next byte to send is always the low one
            if (!FIFO_FULL) begin
              w_inc_q   <= 1'b1;
              tx_data_q <= res_q[DATA_WIDTH-1:0];
              res_q     <= res_q >> DATA_WIDTH;
              if (k_q == KW'(NB - 1)) begin
                k_q     <= {KW{1'b0}};
                state_q <= S_IDLE;
              end else begin
                k_q <= k_q + KW'(1'b1);
              end
            end
          end
          default: begin
            state_q  <= S_IDLE;
            clk_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ALU_FUN    = alu_fun_q;
  assign EN         = en_q;
  assign CLK_EN     = clk_en_q;
  assign Address    = addr_q;
  assign WrEn       = wr_en_q;
  assign RdEn       = rd_en_q;
  assign WrData     = wr_data_q;
  assign TX_P_DATA  = tx_data_q;
  assign W_INC      = w_inc_q;
  assign clk_div_en = clk_div_en_q;
  assign FRAME_ERR  = frame_err_q;

endmodule
